axi_isa_cmd_slave: RTL

- AXI4-Lite slave that generalises the ISA controller register block into a queued command interface.
- Software writes ISA read/write commands into a parametrised-depth command FIFO.
- The block issues each command to the ISA bus engine with an ap_start/ap_idle/ap_done handshake, guarded by a programmable per-command timeout watchdog.
- Sits between the PS AXI interconnect and the ISA bus engine.

---
 rtl/axi_isa_cmd_slave.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_isa_cmd_slave.sv
// AXI4-Lite command slave that queues ISA read/write commands and issues them to the ISA bus engine.
// Optional macro ISA_IRQ_EN adds a sticky interrupt-pending bit (STATUS bit12) driving irq.
module axi_isa_cmd_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int ISA_AW             = 20,
    parameter int ISA_DW             = 16,
    parameter int FIFO_DEPTH         = 4,
    parameter int TO_W               = 16,
    parameter int TO_DEFAULT         = 1000
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            isa_rw,
    output logic [ISA_AW-1:0]               isa_addr,
    output logic [ISA_DW-1:0]               isa_wdata,
    output logic                            ap_start,
    input  logic                            ap_idle,
    input  logic                            ap_done,
    input  logic [ISA_DW-1:0]               isa_rdata,
    output logic                            isa_abort,
    output logic                            irq,
    output logic [1:0]                      dbg_state
);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int ENTRY_W = 1 + ISA_AW + ISA_DW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_CMDADDR = 3'd1;
    localparam logic [2:0] A_CMDDATA = 3'd2;
    localparam logic [2:0] A_RDDATA  = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;
    localparam logic [2:0] A_TIMEOUT = 3'd5;

    // Handshakes: a transfer happens on the edge where both VALID and READY are high.
    // READY is a one-cycle registered pulse; BVALID/RVALID rise the cycle after and hold until B/RREADY.
    logic              awready_q, awready_d, arready_q, arready_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        state_q, state_d;
    logic              ap_start_q, ap_start_d, sr_abort_q, sr_abort_d;
    logic              isa_rw_q, isa_rw_d;
    logic [ISA_AW-1:0] isa_addr_q, isa_addr_d, cmd_addr_q, cmd_addr_d;
    logic [ISA_DW-1:0] isa_wdata_q, isa_wdata_d, rd_data_q, rd_data_d;
    logic              cmd_rw_q, cmd_rw_d, irq_en_q, irq_en_d;
    logic [TO_W-1:0]   timeout_q, timeout_d, to_cnt_q, to_cnt_d;
    logic              rd_valid_q, rd_valid_d, to_flag_q, to_flag_d, ovf_flag_q, ovf_flag_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
`ifdef ISA_IRQ_EN
    logic              irq_pend_q, irq_pend_d;
`endif

    logic [2:0]  waddr, raddr;
    logic        wr_fire, rd_fire, soft_rst, push_req, push_ok, ovf_ev, sts_w1c;
    logic        fifo_full, fifo_empty, start_ev, done_ev, timeout_hit, busy, pend_bit;
    logic [31:0] wr_base, wr_merged, rd_mux, status_w;
    logic [ENTRY_W-1:0] head;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        strb_merge = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) strb_merge[8*i +: 8] = new_v[8*i +: 8];
        end
    endfunction

    assign waddr       = S_AXI_AWADDR[4:2];
    assign raddr       = S_AXI_ARADDR[4:2];
    assign wr_fire     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire     = arready_q & S_AXI_ARVALID;
    assign soft_rst    = wr_fire & (waddr == A_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
    assign sts_w1c     = wr_fire & (waddr == A_STATUS);
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    // Fullness is judged on the pre-pop level, so a push racing a pop on a full FIFO is refused.
    assign push_req    = wr_fire & (waddr == A_CMDDATA);
    assign push_ok     = push_req & ~fifo_full;
    assign ovf_ev      = push_req & fifo_full;
    assign head        = mem_q[rd_ptr_q];
    assign start_ev    = (state_q == ST_IDLE) & ~fifo_empty & ap_idle;
    assign done_ev     = (state_q == ST_WAIT) & ap_done;
    assign timeout_hit = (state_q == ST_WAIT) & ~ap_done & (timeout_q != '0) &
                         (to_cnt_q == timeout_q - TO_W'(1));
    assign busy        = (state_q != ST_IDLE) | ~fifo_empty;
`ifdef ISA_IRQ_EN
    assign pend_bit    = irq_pend_q;
    assign irq         = irq_pend_q & irq_en_q;
`else
    assign pend_bit    = 1'b0;
    assign irq         = 1'b0;
`endif
    assign status_w    = {19'd0, pend_bit, ovf_flag_q, to_flag_q, rd_valid_q, busy, 3'd0, 5'(count_q)};

    always_comb begin
        wr_base = 32'd0;
        case (waddr)
            A_CTRL:    wr_base = {30'd0, irq_en_q, 1'b0};
            A_CMDADDR: wr_base = {cmd_rw_q, {(31-ISA_AW){1'b0}}, cmd_addr_q};
            A_TIMEOUT: wr_base = {{(32-TO_W){1'b0}}, timeout_q};
            default:   wr_base = 32'd0;
        endcase
        wr_merged = strb_merge(wr_base, S_AXI_WDATA, S_AXI_WSTRB);
        rd_mux = 32'd0;
        case (raddr)
            A_CTRL:    rd_mux = {30'd0, irq_en_q, 1'b0};
            A_CMDADDR: rd_mux = {cmd_rw_q, {(31-ISA_AW){1'b0}}, cmd_addr_q};
            A_RDDATA:  rd_mux = {{(32-ISA_DW){1'b0}}, rd_data_q};
            A_STATUS:  rd_mux = status_w;
            A_TIMEOUT: rd_mux = {{(32-TO_W){1'b0}}, timeout_q};
            default:   rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        awready_d   = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        arready_d   = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        bvalid_d    = bvalid_q & ~S_AXI_BREADY;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q & ~S_AXI_RREADY;
        rdata_d     = rdata_q;
        state_d     = state_q;
        ap_start_d  = 1'b0;
        sr_abort_d  = 1'b0;
        isa_rw_d    = isa_rw_q;
        isa_addr_d  = isa_addr_q;
        isa_wdata_d = isa_wdata_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_addr_d  = cmd_addr_q;
        irq_en_d    = irq_en_q;
        timeout_d   = timeout_q;
        to_cnt_d    = to_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        to_flag_d   = to_flag_q;
        ovf_flag_d  = ovf_flag_q;
        wr_ptr_d    = wr_ptr_q + PW'(push_ok);
        rd_ptr_d    = rd_ptr_q + PW'(start_ev);
        count_d     = count_q + CW'(push_ok) - CW'(start_ev);
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = ovf_ev ? 2'b10 : 2'b00;
            case (waddr)
                A_CTRL:    irq_en_d = wr_merged[1];
                A_CMDADDR: begin
                    cmd_rw_d   = wr_merged[31];
                    cmd_addr_d = wr_merged[ISA_AW-1:0];
                end
                A_TIMEOUT: timeout_d = wr_merged[TO_W-1:0];
                default:   ;
            endcase
        end
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
            if (raddr == A_RDDATA) rd_valid_d = 1'b0;
        end
        if (sts_w1c && S_AXI_WDATA[10]) to_flag_d = 1'b0;
        if (sts_w1c && S_AXI_WDATA[11]) ovf_flag_d = 1'b0;
        if (ovf_ev) ovf_flag_d = 1'b1;
        case (state_q)
            ST_IDLE: if (start_ev) begin
                state_d = ST_ISSUE;
                ap_start_d = 1'b1;
                {isa_rw_d, isa_addr_d, isa_wdata_d} = head;
            end
            ST_ISSUE: begin
                state_d  = ST_WAIT;
                to_cnt_d = '0;
            end
            ST_WAIT: if (done_ev) begin
                state_d = ST_IDLE;
                if (isa_rw_q) begin
                    rd_data_d  = isa_rdata;
                    rd_valid_d = 1'b1;
                end
            end else if (timeout_hit) begin
                state_d   = ST_IDLE;
                to_flag_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (soft_rst) begin
            state_d    = ST_IDLE;
            ap_start_d = 1'b0;
            sr_abort_d = (state_q == ST_WAIT);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            to_flag_d  = 1'b0;
            ovf_flag_d = 1'b0;
        end
    end

`ifdef ISA_IRQ_EN
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (sts_w1c && S_AXI_WDATA[12]) irq_pend_d = 1'b0;
        if (done_ev || timeout_hit || ovf_ev) irq_pend_d = 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) irq_pend_q <= 1'b0;
        else                irq_pend_q <= irq_pend_d;
    end
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= {cmd_rw_q, cmd_addr_q, S_AXI_WDATA[ISA_DW-1:0]};
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;  arready_q <= 1'b0;  bvalid_q <= 1'b0;  rvalid_q <= 1'b0;
            bresp_q <= 2'b00;   rdata_q <= 32'd0;   state_q <= ST_IDLE;
            ap_start_q <= 1'b0; sr_abort_q <= 1'b0;
            isa_rw_q <= 1'b0;   isa_addr_q <= '0;   isa_wdata_q <= '0;
            cmd_rw_q <= 1'b0;   cmd_addr_q <= '0;   irq_en_q <= 1'b0;
            timeout_q <= TO_W'(TO_DEFAULT);         to_cnt_q <= '0;
            rd_data_q <= '0;    rd_valid_q <= 1'b0; to_flag_q <= 1'b0; ovf_flag_q <= 1'b0;
            wr_ptr_q <= '0;     rd_ptr_q <= '0;     count_q <= '0;
        end else begin
            awready_q <= awready_d;   arready_q <= arready_d;   bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;     bresp_q <= bresp_d;       rdata_q <= rdata_d;
            state_q <= state_d;       ap_start_q <= ap_start_d; sr_abort_q <= sr_abort_d;
            isa_rw_q <= isa_rw_d;     isa_addr_q <= isa_addr_d; isa_wdata_q <= isa_wdata_d;
            cmd_rw_q <= cmd_rw_d;     cmd_addr_q <= cmd_addr_d; irq_en_q <= irq_en_d;
            timeout_q <= timeout_d;   to_cnt_q <= to_cnt_d;
            rd_data_q <= rd_data_d;   rd_valid_q <= rd_valid_d; to_flag_q <= to_flag_d;
            ovf_flag_q <= ovf_flag_d; wr_ptr_q <= wr_ptr_d;     rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    // Timeout aborts are decided in the expiry cycle itself; SOFT_RST aborts come one cycle after the write.
    assign isa_abort     = timeout_hit | sr_abort_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign isa_rw        = isa_rw_q;
    assign isa_addr      = isa_addr_q;
    assign isa_wdata     = isa_wdata_q;
    assign ap_start      = ap_start_q;
    assign dbg_state     = state_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_merged};
endmodule
